// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage: one shift-add or restoring-divide
// step per cycle, valid/ready on both sides, destination tag carried through to writeback.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             is_word,
  input  logic [XLEN-1:0]  srca,
  input  logic [XLEN-1:0]  srcb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32);
  localparam logic [XLEN-1:0]  MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [XLEN-1:0]      result_q;
  logic [TAG_W-1:0]     out_tag_q;

  op_e                  op_q;
  logic                 is_word_q;
  logic                 neg_q;
  logic [TAG_W-1:0]     tag_q;
  logic [XLEN-1:0]      acc_q;
  logic [XLEN-1:0]      lo_q;
  logic [XLEN-1:0]      opb_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------- request decode ----------------
  op_e             op_in;
  logic            is_div_in;
  logic            a_signed, b_signed;
  logic            neg_a_in, neg_b_in, neg_res_in;
  logic [XLEN-1:0] a_x, b_x, mag_a, mag_b, a_sx;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign op_in     = op_e'(op);
  assign is_div_in = op[2];
  assign a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                     (op_in == OP_DIV)  || (op_in == OP_REM);
  assign b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);

  assign a_x = is_word ? (a_signed ? sext32(srca[31:0]) : XLEN'(srca[31:0])) : srca;
  assign b_x = is_word ? (b_signed ? sext32(srcb[31:0]) : XLEN'(srcb[31:0])) : srcb;

  assign neg_a_in = a_signed && a_x[XLEN-1];
  assign neg_b_in = b_signed && b_x[XLEN-1];
  assign mag_a    = neg_a_in ? -a_x : a_x;
  assign mag_b    = neg_b_in ? -b_x : b_x;
  // The remainder follows the dividend; quotients and products follow the sign product.
  assign neg_res_in = (op_in == OP_REM) ? neg_a_in : (neg_a_in ^ neg_b_in);

  assign a_sx     = is_word ? sext32(srca[31:0]) : srca;
  assign div_zero = is_div_in && (is_word ? (srcb[31:0] == 32'd0) : (srcb == '0));
  assign div_ovf  = is_div_in && !op[0] &&
                    (is_word ? (srca[31:0] == 32'h8000_0000 && srcb[31:0] == 32'hFFFF_FFFF)
                             : (srca == MIN_X && srcb == '1));
  assign special  = div_zero || div_ovf;
  assign special_res = div_zero ? (op[1] ? a_sx : '1) : (op[1] ? '0 : a_sx);

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_step, lo_step;

  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {acc_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_ge   = !div_diff[XLEN];

  assign acc_step = op_q[2] ? (div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0])
                            : mul_sum[XLEN:1];
  assign lo_step  = op_q[2] ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};

  // ---------------- sign fix-up of the final step ----------------
  logic [XLEN-1:0] mul_hi, div_val, div_fix, final_res;

  // High half of the negated 2*XLEN product: ~hi plus the carry out of -lo.
  assign mul_hi  = neg_q ? (~acc_step + XLEN'(lo_step == '0)) : acc_step;
  assign div_val = op_q[1] ? acc_step : lo_step;
  assign div_fix = neg_q ? -div_val : div_val;

  assign final_res = is_word_q ? (op_q[2] ? sext32(div_fix[31:0])
                                          : sext32(lo_step[XLEN-1 -: 32]))
                               : (op_q[2] ? div_fix
                                          : ((op_q == OP_MUL) ? lo_step : mul_hi));

  // ---------------- control FSM ----------------
  // NOTE: clocked blocks use non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (special) begin
              state_q   <= S_DONE;
              result_q  <= special_res;
              out_tag_q <= in_tag;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= is_word ? N_WORD : N_FULL;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= S_DONE;
            result_q  <= final_res;
            out_tag_q <= tag_q;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  // NOTE: datapath registers are deliberately not reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) begin
      op_q      <= op_in;
      is_word_q <= is_word;
      neg_q     <= neg_res_in;
      tag_q     <= in_tag;
      acc_q     <= '0;
      if (is_div_in) begin
        // W divides start with the dividend left-aligned so its MSB shifts out first.
        lo_q  <= is_word ? (mag_a << (XLEN - 32)) : mag_a;
        opb_q <= mag_b;
      end else begin
        lo_q  <= mag_b;
        opb_q <= mag_a;
      end
    end else if (state_q == S_BUSY) begin
      acc_q <= acc_step;
      lo_q  <= lo_step;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign out_tag   = out_tag_q;

endmodule
